// File: rtl/seq_divider_if.sv
// Handshake/operand bundle between the ALU control FSM (master) and seq_divider (slave).
// DIV_ZERO_DETECT_EN adds the div_by_zero result flag.
interface seq_divider_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
`ifdef DIV_ZERO_DETECT_EN
  logic             div_by_zero;

  modport master (output start, dividend, divisor,
                  input  busy, done, quotient, remainder, div_by_zero);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quotient, remainder, div_by_zero);
`else
  modport master (output start, dividend, divisor,
                  input  busy, done, quotient, remainder);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quotient, remainder);
`endif
endinterface

// File: rtl/seq_divider.sv
// Iterative signed restoring divider, one quotient bit per clock, truncating toward zero.
// Optional DIV_ZERO_DETECT_EN: zero divisor short-cuts to DONE and raises div_by_zero.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_divider_if.slave   bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d, m_q, m_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sq_q, sq_d, sr_q, sr_d;
  logic             accept, dz_start;
  logic [WIDTH:0]   r_sh, t;

  assign accept = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
`ifdef DIV_ZERO_DETECT_EN
  logic dz_q, dz_d;
  assign dz_start = accept && (bus.divisor == '0);
`else
  assign dz_start = 1'b0;
`endif

  // Trial subtraction; R < M keeps r_sh below 2^WIDTH, so t[WIDTH] is the sign.
  assign r_sh = {r_q, q_q[WIDTH-1]};
  assign t    = r_sh - {1'b0, m_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = dz_start ? DONE : CALC;
      CALC:    if (cnt_q == CW'(1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = accept ? (dz_start ? DONE : CALC) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == CALC) || (state_q == FIX);
    bus.done = (state_q == DONE);
  end

  always_comb begin
    q_d    = q_q;
    r_d    = r_q;
    m_d    = m_q;
    cnt_d  = cnt_q;
    sq_d   = sq_q;
    sr_d   = sr_q;
    quot_d = quot_q;
    rem_d  = rem_q;
`ifdef DIV_ZERO_DETECT_EN
    dz_d   = dz_q;
`endif
    if (accept) begin
      sq_d  = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      sr_d  = bus.dividend[WIDTH-1];
      q_d   = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
      m_d   = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
      r_d   = '0;
      cnt_d = CW'(WIDTH);
`ifdef DIV_ZERO_DETECT_EN
      if (dz_start) begin
        quot_d = '1;
        rem_d  = bus.dividend;
        dz_d   = 1'b1;
      end
`endif
    end else if (state_q == CALC) begin
      if (!t[WIDTH]) begin
        r_d = t[WIDTH-1:0];
        q_d = {q_q[WIDTH-2:0], 1'b1};
      end else begin
        r_d = r_sh[WIDTH-1:0];
        q_d = {q_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
    end else if (state_q == FIX) begin
      quot_d = sq_q ? -q_q : q_q;
      rem_d  = sr_q ? -r_q : r_q;
`ifdef DIV_ZERO_DETECT_EN
      dz_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= '0;
      r_q    <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      sq_q   <= 1'b0;
      sr_q   <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
    end else begin
      q_q    <= q_d;
      r_q    <= r_d;
      m_q    <= m_d;
      cnt_q  <= cnt_d;
      sq_q   <= sq_d;
      sr_q   <= sr_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dz_q <= 1'b0;
    else        dz_q <= dz_d;
  end
  assign bus.div_by_zero = dz_q;
`endif

  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
endmodule

// File: tb/tb_seq_divider.sv
// Randomized + directed bench for seq_divider against a plain-arithmetic division model.
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] last_q = '0, last_r = '0;

  seq_divider_if #(.WIDTH(16)) bus ();
  seq_divider #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Truncating signed division; zero divisor follows the documented fallbacks.
  task automatic ref_div(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r, output logic dz);
    int ai, bi, qi, ri;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0) begin
`ifdef DIV_ZERO_DETECT_EN
      q = 16'hFFFF; dz = 1'b1;
`else
      q = (ai >= 0) ? 16'hFFFF : 16'h0001; dz = 1'b0;
`endif
      r = a;
    end else begin
      qi = ai / bi;
      ri = ai % bi;
      q = qi[15:0];
      r = ri[15:0];
      dz = 1'b0;
    end
  endtask

  // Drives start now; caller places this away from the clock edge.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int poke);
    logic [15:0] eq, er;
    logic edz;
    int n, bc, exp_lat, exp_busy;
    bit seen;
    ref_div(a, b, eq, er, edz);
    exp_lat = 18; exp_busy = 17;
`ifdef DIV_ZERO_DETECT_EN
    if (b == 16'h0) begin exp_lat = 1; exp_busy = 0; end
`endif
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    n = 0; bc = 0; seen = 0;
    while (!seen && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (bus.busy) bc++;
      if (bus.done) seen = 1;
      if (n == poke) begin
        bus.start = 1'b1; bus.dividend = 16'd999; bus.divisor = 16'd3;
      end else begin
        bus.start = 1'b0; bus.dividend = 16'($urandom); bus.divisor = 16'($urandom);
      end
    end
    chk($sformatf("latency %h/%h", a, b), n, exp_lat);
    chk($sformatf("busy_cycles %h/%h", a, b), bc, exp_busy);
    chk($sformatf("quotient %h/%h", a, b), bus.quotient, eq);
    chk($sformatf("remainder %h/%h", a, b), bus.remainder, er);
`ifdef DIV_ZERO_DETECT_EN
    chk($sformatf("div_by_zero %h/%h", a, b), bus.div_by_zero, edz);
`endif
    last_q = eq; last_r = er;
  endtask

  task automatic hold_check(input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
      chk("done_pulse_width", bus.done, 1'b0);
      chk("quotient_held", bus.quotient, last_q);
      chk("remainder_held", bus.remainder, last_r);
    end
  endtask

  initial begin
    logic [15:0] ra, rb;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    #12;
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_quotient", bus.quotient, 16'h0);
    chk("reset_remainder", bus.remainder, 16'h0);
`ifdef DIV_ZERO_DETECT_EN
    chk("reset_dz", bus.div_by_zero, 1'b0);
`endif
    @(negedge clk); rst_n = 1'b1;

    @(negedge clk); do_op(16'd7, 16'd2, -1);            hold_check(2);
    @(negedge clk); do_op(16'hFF97, 16'h002E, -1);      hold_check(1);
    @(negedge clk); do_op(16'hFFF9, 16'd2, -1);
    @(negedge clk); do_op(16'h8000, 16'hFFFF, -1);
    @(negedge clk); do_op(16'h8000, 16'h0001, -1);
    @(negedge clk); do_op(16'd100, 16'd7, 5);
    // back-to-back: start held during the DONE cycle
    do_op(16'd9, 16'd3, -1);                            hold_check(2);

    // async reset in the middle of CALC
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 16'd1234; bus.divisor = 16'd5;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", bus.busy, 1'b0);
    chk("async_rst_done", bus.done, 1'b0);
    chk("async_rst_quotient", bus.quotient, 16'h0);
    chk("async_rst_remainder", bus.remainder, 16'h0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_done_in_reset", bus.done, 1'b0);
    end
    @(negedge clk); rst_n = 1'b1;
    last_q = '0; last_r = '0;
    hold_check(2);

    @(negedge clk); do_op(16'd1234, 16'd5, -1);
    @(negedge clk); do_op(16'd50, 16'd0, -1);           hold_check(1);
    @(negedge clk); do_op(16'd9, 16'd3, -1);
    @(negedge clk); do_op(16'hFFCE, 16'd0, -1);

    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      if ($urandom_range(0, 9) == 0) ra = 16'h8000;
      case ($urandom_range(0, 7))
        0:       rb = 16'h0000;
        1:       rb = 16'hFFFF;
        2, 3:    rb = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(1, 20))
                                                  : -16'($urandom_range(1, 20));
        default: rb = 16'($urandom);
      endcase
      if ($urandom_range(0, 2) == 0) do_op(ra, rb, -1);
      else begin @(negedge clk); do_op(ra, rb, -1); end
    end
    hold_check(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
